// File: rtl/pwm_ss_multiphase_pkg.sv
// Shared types and defaults for the multiphase soft-start PWM.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } pwm_state_e;

  localparam int unsigned DEF_CNT_W  = 8;
  localparam int unsigned DEF_DT_W   = 4;
  localparam int unsigned DEF_PHASES = 2;
  localparam int unsigned DEF_SS_DIV = 4;

  function automatic int unsigned phase_offset(input int unsigned k,
                                               input int unsigned cnt_w  = DEF_CNT_W,
                                               input int unsigned phases = DEF_PHASES);
    return ((32'd1 << cnt_w) / phases) * k;
  endfunction

endpackage

// File: rtl/pwm_ss_multiphase_deadtime.sv
// Per-channel dead-time generator: converts one raw PWM bit into a
// non-overlapping complementary gate pair.
module pwm_deadtime #(
  parameter int unsigned DT_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            raw,
  input  logic [DT_W-1:0] dt1,
  input  logic [DT_W-1:0] dt2,
  output logic            c1,
  output logic            c2
);

  logic            armed;
  logic            raw_q;
  logic            pend;
  logic [DT_W-1:0] dcnt;
  logic [DT_W-1:0] dly;

  assign dly = raw ? dt1 : dt2;

  // The first cycle after run rises is treated as an edge, so the low side
  // also waits out its dead-time when leaving idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      raw_q <= 1'b0;
      pend  <= 1'b0;
      dcnt  <= '0;
      c1    <= 1'b0;
      c2    <= 1'b0;
    end else if (!run) begin
      armed <= 1'b0;
      raw_q <= 1'b0;
      pend  <= 1'b0;
      dcnt  <= '0;
      c1    <= 1'b0;
      c2    <= 1'b0;
    end else begin
      armed <= 1'b1;
      raw_q <= raw;
      if (!armed || (raw != raw_q)) begin
        if (dly == '0) begin
          c1   <= raw;
          c2   <= ~raw;
          pend <= 1'b0;
        end else begin
          c1   <= 1'b0;
          c2   <= 1'b0;
          pend <= 1'b1;
          dcnt <= dly - DT_W'(1);
        end
      end else if (pend) begin
        if (dcnt == '0) begin
          c1   <= raw;
          c2   <= ~raw;
          pend <= 1'b0;
        end else begin
          dcnt <= dcnt - DT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pwm_ss_multiphase.sv
// Multiphase complementary PWM with soft-start ramp and dead-time.
// Optional fault latch enabled by defining PWM_FAULT_LATCH_EN.
module pwm_ss_multiphase
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned DT_W   = DEF_DT_W,
  parameter int unsigned PHASES = DEF_PHASES,
  parameter int unsigned SS_DIV = DEF_SS_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [CNT_W-1:0]  i_duty,
  input  logic [DT_W-1:0]   i_dt1,
  input  logic [DT_W-1:0]   i_dt2,
  output logic [PHASES-1:0] o_c1,
  output logic [PHASES-1:0] o_c2,
  output logic              o_sync,
`ifdef PWM_FAULT_LATCH_EN
  input  logic              i_fault,
  output logic              o_fault,
`endif
  output logic              o_ss_done
);

  localparam int unsigned DIV_W = (SS_DIV > 1) ? $clog2(SS_DIV) : 1;

  pwm_state_e        state, state_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  duty_act, duty_d, nd;
  logic [CNT_W:0]    nd_w;
  logic [DIV_W-1:0]  div, div_d;
  logic              boundary, tick, active, gate_run;
  logic [PHASES-1:0] raw;

  assign boundary  = (cnt == '1);
  assign tick      = (div == DIV_W'(SS_DIV - 1));
  assign active    = (state == RAMP) || (state == RUN);
  assign o_ss_done = (state == RUN);

`ifdef PWM_FAULT_LATCH_EN
  assign o_fault  = (state == FAULT);
  assign gate_run = enable && active && !i_fault;
`else
  assign gate_run = enable && active;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      o_sync   <= 1'b0;
      state    <= IDLE;
      duty_act <= '0;
      div      <= '0;
    end else begin
      cnt      <= cnt + CNT_W'(1);
      o_sync   <= boundary;
      state    <= state_d;
      duty_act <= duty_d;
      div      <= div_d;
    end
  end

  // Ramp step: min(duty+1, target) on a divider tick, min(duty, target)
  // otherwise, so a zero or lowered target finishes at the next boundary.
  always_comb begin
    nd_w = tick ? ({1'b0, duty_act} + (CNT_W+1)'(1)) : {1'b0, duty_act};
    nd   = (nd_w > {1'b0, i_duty}) ? i_duty : nd_w[CNT_W-1:0];
  end

  always_comb begin
    state_d = state;
    duty_d  = duty_act;
    div_d   = div;
    case (state)
      IDLE: begin
        duty_d = '0;
        if (enable && boundary) begin
          state_d = RAMP;
          div_d   = '0;
        end
      end
      RAMP: begin
        if (boundary) begin
          div_d  = tick ? '0 : div + DIV_W'(1);
          duty_d = nd;
          if (nd == i_duty) state_d = RUN;
        end
      end
      RUN: begin
        if (boundary) duty_d = i_duty;
      end
      FAULT: begin
        duty_d = '0;
      end
      default: begin
        state_d = IDLE;
        duty_d  = '0;
      end
    endcase
`ifdef PWM_FAULT_LATCH_EN
    if (i_fault && (state != IDLE)) begin
      state_d = FAULT;
      duty_d  = '0;
    end
`endif
    if (!enable) begin
      state_d = IDLE;
      duty_d  = '0;
    end
  end

  for (genvar k = 0; k < PHASES; k++) begin : g_phase
    localparam int unsigned OFFS = phase_offset(k, CNT_W, PHASES);
    logic [CNT_W-1:0] pcnt;

    assign pcnt   = cnt + CNT_W'(OFFS);
    assign raw[k] = active && (pcnt < duty_act);

    pwm_deadtime #(.DT_W(DT_W)) u_dt (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (gate_run),
      .raw   (raw[k]),
      .dt1   (i_dt1),
      .dt2   (i_dt2),
      .c1    (o_c1[k]),
      .c2    (o_c2[k])
    );
  end

endmodule

// File: tb/tb_pwm_ss_multiphase.sv
// Self-checking bench for pwm_ss_multiphase (CNT_W=8, PHASES=2).
`timescale 1ns/1ps
module tb_pwm_ss_multiphase;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] i_duty;
  logic [3:0] i_dt1, i_dt2;
  logic [1:0] o_c1, o_c2;
  logic       o_sync, o_ss_done;

  logic       enable_b = 1'b1;
  logic [7:0] duty_b   = 8'd8;
  logic [3:0] dt_b     = 4'd0;
  logic [1:0] c1b, c2b;
  logic       syncb, doneb;
`ifdef PWM_FAULT_LATCH_EN
  logic       i_fault = 1'b0;
  logic       o_fault;
  logic       fault_b = 1'b0;
  logic       o_fault_b;
`endif

  int checks = 0;
  int errors = 0;
  int hp[0:7];

  always #5 clk = ~clk;

  pwm_ss_multiphase #(.CNT_W(8), .DT_W(4), .PHASES(2), .SS_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .i_duty(i_duty),
    .i_dt1(i_dt1), .i_dt2(i_dt2), .o_c1(o_c1), .o_c2(o_c2), .o_sync(o_sync),
`ifdef PWM_FAULT_LATCH_EN
    .i_fault(i_fault), .o_fault(o_fault),
`endif
    .o_ss_done(o_ss_done)
  );

  pwm_ss_multiphase #(.CNT_W(8), .DT_W(4), .PHASES(2), .SS_DIV(4)) dut_div4 (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .i_duty(duty_b),
    .i_dt1(dt_b), .i_dt2(dt_b), .o_c1(c1b), .o_c2(c2b), .o_sync(syncb),
`ifdef PWM_FAULT_LATCH_EN
    .i_fault(fault_b), .o_fault(o_fault_b),
`endif
    .o_ss_done(doneb)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    checks++;
    if (((o_c1 & o_c2) | (c1b & c2b)) != 2'b00) begin
      errors++;
      $display("FAIL overlap: c1=%b c2=%b c1b=%b c2b=%b, want no common bit", o_c1, o_c2, c1b, c2b);
    end
  end

  task automatic wait_sync(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (o_sync) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One carrier period starting at the sync cycle: high counts, both-low gap
  // preceding each rise on phase 0, and phase-1 rise lag.
  task automatic measure(output int h1, output int h2, output int h1b,
                         output int g1, output int g2, output int lag, output bit ok);
    int idx = -1, lowrun = 0, pos0 = -1, pos1 = -1;
    bit p1 = o_c1[0], p2 = o_c2[0], pb = o_c1[1];
    h1 = 0; h2 = 0; h1b = 0; g1 = -1; g2 = -1; ok = 1'b0;
    for (int n = 0; n < 900; n++) begin
      @(negedge clk);
      if (idx < 0 && o_sync) idx = 0;
      if (idx >= 0) begin
        h1  += int'(o_c1[0]);
        h2  += int'(o_c2[0]);
        h1b += int'(o_c1[1]);
        if (o_c1[0] && !p1) begin g1 = lowrun; if (pos0 < 0) pos0 = idx; end
        if (o_c2[0] && !p2) g2 = lowrun;
        if (o_c1[1] && !pb && pos1 < 0) pos1 = idx;
        idx++;
      end
      lowrun = (!o_c1[0] && !o_c2[0]) ? lowrun + 1 : 0;
      p1 = o_c1[0]; p2 = o_c2[0]; pb = o_c1[1];
      if (idx == 256) begin
        ok = 1'b1;
        break;
      end
    end
    lag = (pos0 >= 0 && pos1 >= 0) ? (pos1 - pos0 + 256) % 256 : -1;
  endtask

  // hp[k] = phase-0 high-side clocks in the period after the k-th sync.
  task automatic count_ramp(input int nper, output bit ok);
    int sync_n = 0, hi = 0;
    ok = 1'b0;
    for (int n = 0; n < (nper + 2) * 256 + 600; n++) begin
      @(negedge clk);
      if (o_sync) begin
        if (sync_n >= 1) hp[sync_n] = hi;
        sync_n++;
        hi = 0;
        if (sync_n > nper) begin
          ok = 1'b1;
          break;
        end
      end
      hi += int'(o_c1[0]);
    end
  endtask

  typedef struct {
    int duty; int dt1; int dt2;
    int c1; int c2; int g1; int g2; int lag;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit ok;
    int cyc, sync_n, hi, first_sync, done_at, doneb_at, gates_on;
    int h1, h2, h1b, g1, g2, lag;
    int hper[0:7];

    vecs[0] = '{128, 3, 5, 125, 123, 3, 5, 128};
    vecs[1] = '{ 64, 0, 0,  64, 192, 0, 0, 128};
    vecs[2] = '{ 50, 0, 0,  50, 206, 0, 0, 128};
    vecs[3] = '{  0, 2, 2,   0, 256, -1, -1, -1};
    vecs[4] = '{255, 0, 0, 255,   1, 0, 0, 128};
    vecs[5] = '{255, 2, 0, 253,   1, 2, 0, 128};
    vecs[6] = '{255, 1, 3, 254,   0, 2, -1, 128};
    vecs[7] = '{100, 15, 15, 85, 141, 15, 15, 128};
    vecs[8] = '{  1, 4, 0,   0, 255, -1, 1, -1};

    rst_n = 1'b0; enable = 1'b0; i_duty = 8'd64; i_dt1 = 4'd0; i_dt2 = 4'd0;
    #23;
    check("reset_outputs", int'({o_c1, o_c2, o_sync, o_ss_done}), 0);

    // Soft-start from reset, also timing the first sync pulse.
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1;
    cyc = 0; sync_n = 0; hi = 0; first_sync = -1; done_at = -1; doneb_at = -1;
    for (int n = 0; n < 70 * 256; n++) begin
      @(posedge clk); #1;
      cyc++;
      if (o_sync) begin
        if (sync_n >= 1 && sync_n <= 7) hper[sync_n] = hi;
        sync_n++;
        hi = 0;
        if (first_sync < 0) first_sync = cyc;
      end
      hi += int'(o_c1[0]);
      if (o_ss_done && done_at < 0) done_at = sync_n;
      if (doneb && doneb_at < 0) doneb_at = sync_n;
      if (done_at >= 0 && doneb_at >= 0) break;
    end
    check("first_sync_clocks", first_sync, 256);
    for (int k = 1; k <= 5; k++) check($sformatf("ramp_hi_p%0d", k), hper[k], k - 1);
    check("ss_done_boundary", done_at, 65);
    check("ss_done_boundary_div4", doneb_at, 33);

    // Duty step in RUN applies only at the following boundary.
    wait_sync(ok);
    check("step_sync_timeout", int'(ok), 1);
    hi = int'(o_c1[0]);
    for (int idx = 1; idx < 256; idx++) begin
      @(negedge clk);
      hi += int'(o_c1[0]);
      if (idx == 5) i_duty = 8'd10;
    end
    check("step_same_period", hi, 64);
    measure(h1, h2, h1b, g1, g2, lag, ok);
    check("step_next_period", h1, 10);

    for (int i = 0; i < 9; i++) begin
      i_duty = 8'(vecs[i].duty);
      i_dt1  = 4'(vecs[i].dt1);
      i_dt2  = 4'(vecs[i].dt2);
      measure(h1, h2, h1b, g1, g2, lag, ok);
      measure(h1, h2, h1b, g1, g2, lag, ok);
      check($sformatf("v%0d_timeout", i), int'(ok), 1);
      check($sformatf("v%0d_c1_hi", i), h1, vecs[i].c1);
      check($sformatf("v%0d_c2_hi", i), h2, vecs[i].c2);
      check($sformatf("v%0d_c1b_hi", i), h1b, vecs[i].c1);
      check($sformatf("v%0d_gap1", i), g1, vecs[i].g1);
      check($sformatf("v%0d_gap2", i), g2, vecs[i].g2);
      check($sformatf("v%0d_lag", i), lag, vecs[i].lag);
    end

    // Asynchronous reset in the middle of a high-side pulse.
    i_duty = 8'd100; i_dt1 = 4'd0; i_dt2 = 4'd0;
    wait_sync(ok); wait_sync(ok);
    repeat (50) @(negedge clk);
    check("pre_reset_c1", int'(o_c1[0]), 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", int'({o_c1, o_c2, o_sync, o_ss_done}), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc = 0; first_sync = -1; gates_on = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      cyc++;
      gates_on += int'(o_c1 != 2'b00 || o_c2 != 2'b00 || o_ss_done);
      if (o_sync) begin
        first_sync = cyc;
        break;
      end
    end
    check("rerst_first_sync", first_sync, 256);
    check("rerst_idle_gates", gates_on, 0);

    // Enable drop mid-ramp at duty_act=20, then restart the ramp.
    enable = 1'b0;
    repeat (3) @(negedge clk);
    i_duty = 8'd64;
    enable = 1'b1;
    for (int k = 0; k < 21; k++) wait_sync(ok);
    check("drop_sync_timeout", int'(ok), 1);
    repeat (10) @(negedge clk);
    check("drop_pre_c1", int'(o_c1[0]), 1);
    enable = 1'b0;
    @(posedge clk); #1;
    check("drop_gates_next", int'({o_c1, o_c2}), 0);
    check("drop_ss_done", int'(o_ss_done), 0);
    repeat (30) @(negedge clk);
    check("drop_gates_held", int'({o_c1, o_c2}), 0);
    enable = 1'b1;
    count_ramp(3, ok);
    check("reramp_timeout", int'(ok), 1);
    for (int k = 1; k <= 3; k++) check($sformatf("reramp_hi_p%0d", k), hp[k], k - 1);

`ifdef PWM_FAULT_LATCH_EN
    i_duty = 8'd3;
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (o_ss_done) begin ok = 1'b1; break; end
    end
    check("fault_run_timeout", int'(ok), 1);
    i_fault = 1'b1;
    @(posedge clk); #1;
    check("fault_gates", int'({o_c1, o_c2}), 0);
    check("fault_flag", int'(o_fault), 1);
    @(negedge clk);
    i_fault = 1'b0;
    repeat (300) @(negedge clk);
    check("fault_held", int'({o_fault, o_ss_done, o_c1, o_c2}), 32);
    enable = 1'b0;
    @(posedge clk); #1;
    check("fault_cleared", int'(o_fault), 0);
    @(negedge clk);
    enable = 1'b1;
    count_ramp(2, ok);
    check("fault_reramp_timeout", int'(ok), 1);
    check("fault_reramp_p1", hp[1], 0);
    check("fault_reramp_p2", hp[2], 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
